pll_input_decimator: RTL



---
 rtl/pll_input_decimator_if.sv | 24 ++
 rtl/pll_input_decimator.sv | 83 ++++++++
 2 files changed

// File: rtl/pll_input_decimator_if.sv
// Sample/average bus of the PLL input decimator.
// The slave modport is the decimator; the master modport is the sample source and result consumer.
interface pll_input_decimator_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int LOG2_W = 3
);
    logic [N_CH*DATA_W-1:0] data_i;
    logic                   valid_i;
    logic [LOG2_W-1:0]      log2_dec_i;
    logic                   clear_i;
    logic [N_CH*DATA_W-1:0] data_o;
    logic                   valid_o;

    modport master (
        output data_i, valid_i, log2_dec_i, clear_i,
        input  data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, log2_dec_i, clear_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/pll_input_decimator.sv
// Multi-channel boxcar decimator: averages N_CH signed streams over 2^L samples,
// where L is latched at the first sample of each frame.
module pll_input_decimator #(
    parameter int DATA_W   = 8,
    parameter int N_CH     = 2,
    parameter int MAX_LOG2 = 4,
    parameter int LOG2_W   = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    pll_input_decimator_if.slave bus
);
    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic signed [ACC_W-1:0]  acc_q [N_CH];
    logic signed [ACC_W-1:0]  acc_d [N_CH];
    logic signed [ACC_W-1:0]  sum_w [N_CH];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LOG2_W-1:0]        active_l_q, active_l_d;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic                     valid_q, valid_d;
    logic [N_CH*DATA_W-1:0]   avg_w;
    logic [LOG2_W-1:0]        lc_w;
    logic [LOG2_W-1:0]        l_eff_w;
    logic                     last_w;

    assign lc_w    = (bus.log2_dec_i > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : bus.log2_dec_i;
    assign l_eff_w = (cnt_q == '0) ? lc_w : active_l_q;
    assign last_w  = (32'(cnt_q) == ((32'd1 << l_eff_w) - 32'd1));

    // Accumulator has MAX_LOG2 guard bits, so the running sum never wraps.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [DATA_W-1:0] samp_w;
            assign samp_w = bus.data_i[gi*DATA_W +: DATA_W];
            assign sum_w[gi] = acc_q[gi] + ACC_W'(samp_w);
            assign avg_w[gi*DATA_W +: DATA_W] = DATA_W'(sum_w[gi] >>> l_eff_w);
        end
    endgenerate

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        active_l_d = active_l_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        if (bus.clear_i) begin
            for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
            cnt_d = '0;
        end else if (bus.valid_i) begin
            if (cnt_q == '0) active_l_d = lc_w;
            if (last_w) begin
                data_d  = avg_w;
                valid_d = 1'b1;
                for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
                cnt_d = '0;
            end else begin
                for (int k = 0; k < N_CH; k++) acc_d[k] = sum_w[k];
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
            cnt_q      <= '0;
            active_l_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_d[k];
            cnt_q      <= cnt_d;
            active_l_q <= active_l_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
endmodule
